// File: rtl/alu_muldiv.sv
// ALU with single-cycle logic/arithmetic ops and an iterative unsigned
// multiply/divide unit that writes its 2*WIDTH-bit outcome into HI/LO.
module alu_muldiv #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 6
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [3:0]       alu_control,
    input  logic [WIDTH-1:0] operand1,
    input  logic [WIDTH-1:0] operand2,
    output logic             out_valid,
    output logic [WIDTH-1:0] result,
    output logic             zero,
    output logic             overflow,
    output logic             busy
);

    localparam logic [3:0] OP_AND   = 4'b0000;
    localparam logic [3:0] OP_OR    = 4'b0001;
    localparam logic [3:0] OP_ADD   = 4'b0010;
    localparam logic [3:0] OP_SUB   = 4'b0110;
    localparam logic [3:0] OP_SLT   = 4'b0111;
    localparam logic [3:0] OP_SLTU  = 4'b1000;
    localparam logic [3:0] OP_NOR   = 4'b1100;
    localparam logic [3:0] OP_MULTU = 4'b1001;
    localparam logic [3:0] OP_DIVU  = 4'b1010;
    localparam logic [3:0] OP_MFHI  = 4'b1101;
    localparam logic [3:0] OP_MFLO  = 4'b1110;

    localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(WIDTH - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_MUL  = 2'd1,
        S_DIV  = 2'd2,
        S_DONE = 2'd3
    } state_t;

    state_t               state_q, state_d;
    logic [WIDTH-1:0]     hi_q, hi_d, lo_q, lo_d;
    logic [2*WIDTH-1:0]   work_q, work_d;
    logic [WIDTH-1:0]     opb_q, opb_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic [WIDTH-1:0]     result_q, result_d;
    logic                 out_valid_q, out_valid_d;
    logic                 zero_q, zero_d;
    logic                 overflow_q, overflow_d;

    logic [WIDTH-1:0]     sum_s, diff_s, alu_res_s;
    logic                 alu_ovf_s;
    logic [2*WIDTH-1:0]   mul_next_s, div_next_s;

    // One shift-add step: work = {partial product, remaining multiplier bits}.
    function automatic logic [2*WIDTH-1:0] mul_step(input logic [2*WIDTH-1:0] p,
                                                    input logic [WIDTH-1:0]   mcand);
        logic [WIDTH:0] sum;
        sum = {1'b0, p[2*WIDTH-1:WIDTH]} + {1'b0, (p[0] ? mcand : {WIDTH{1'b0}})};
        return {sum, p[WIDTH-1:1]};
    endfunction

    // One restoring step: work = {partial remainder, dividend/quotient bits}.
    function automatic logic [2*WIDTH-1:0] div_step(input logic [2*WIDTH-1:0] rq,
                                                    input logic [WIDTH-1:0]   dvs);
        logic [WIDTH:0] trial;
        logic [WIDTH:0] diff;
        trial = {rq[2*WIDTH-1:WIDTH], rq[WIDTH-1]};
        diff  = trial - {1'b0, dvs};
        if (trial >= {1'b0, dvs}) begin
            return {diff[WIDTH-1:0], rq[WIDTH-2:0], 1'b1};
        end else begin
            return {trial[WIDTH-1:0], rq[WIDTH-2:0], 1'b0};
        end
    endfunction

    function automatic logic signed_ovf(input logic a_sign, input logic b_sign,
                                        input logic r_sign);
        return (a_sign == b_sign) && (r_sign != a_sign);
    endfunction

    assign sum_s      = operand1 + operand2;
    assign diff_s     = operand1 - operand2;
    assign mul_next_s = mul_step(work_q, opb_q);
    assign div_next_s = div_step(work_q, opb_q);

    // Single-cycle datapath on the request operands.
    always_comb begin
        alu_res_s = {WIDTH{1'b0}};
        alu_ovf_s = 1'b0;
        case (alu_control)
            OP_AND:  alu_res_s = operand1 & operand2;
            OP_OR:   alu_res_s = operand1 | operand2;
            OP_ADD: begin
                alu_res_s = sum_s;
                alu_ovf_s = signed_ovf(operand1[WIDTH-1], operand2[WIDTH-1], sum_s[WIDTH-1]);
            end
            OP_SUB: begin
                alu_res_s = diff_s;
                alu_ovf_s = signed_ovf(operand1[WIDTH-1], ~operand2[WIDTH-1], diff_s[WIDTH-1]);
            end
            OP_SLT:  alu_res_s = {{(WIDTH-1){1'b0}}, ($signed(operand1) < $signed(operand2))};
            OP_SLTU: alu_res_s = {{(WIDTH-1){1'b0}}, (operand1 < operand2)};
            OP_NOR:  alu_res_s = ~(operand1 | operand2);
            OP_MFHI: alu_res_s = hi_q;
            OP_MFLO: alu_res_s = lo_q;
            default: alu_res_s = {WIDTH{1'b0}};
        endcase
    end

    // Next-state, iteration and result-register logic.
    always_comb begin
        state_d     = state_q;
        hi_d        = hi_q;
        lo_d        = lo_q;
        work_d      = work_q;
        opb_d       = opb_q;
        cnt_d       = cnt_q;
        result_d    = result_q;
        out_valid_d = 1'b0;
        zero_d      = zero_q;
        overflow_d  = overflow_q;
        case (state_q)
            S_IDLE: begin
                if (in_valid) begin
                    if (alu_control == OP_MULTU) begin
                        state_d = S_MUL;
                        work_d  = {{WIDTH{1'b0}}, operand2};
                        opb_d   = operand1;
                        cnt_d   = {CNT_W{1'b0}};
                    end else if (alu_control == OP_DIVU && operand2 != {WIDTH{1'b0}}) begin
                        state_d = S_DIV;
                        work_d  = {{WIDTH{1'b0}}, operand1};
                        opb_d   = operand2;
                        cnt_d   = {CNT_W{1'b0}};
                    end else if (alu_control == OP_DIVU) begin
                        // Divide by zero completes at once with the MIPS-style outcome.
                        hi_d        = operand1;
                        lo_d        = {WIDTH{1'b1}};
                        result_d    = {WIDTH{1'b1}};
                        zero_d      = 1'b0;
                        overflow_d  = 1'b0;
                        out_valid_d = 1'b1;
                    end else begin
                        result_d    = alu_res_s;
                        zero_d      = (alu_res_s == {WIDTH{1'b0}});
                        overflow_d  = alu_ovf_s;
                        out_valid_d = 1'b1;
                    end
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_MUL, S_DIV: begin
                work_d = (state_q == S_MUL) ? mul_next_s : div_next_s;
                cnt_d  = cnt_q + CNT_W'(1);
                if (cnt_q == LAST_ITER) begin
                    state_d     = S_DONE;
                    hi_d        = work_d[2*WIDTH-1:WIDTH];
                    lo_d        = work_d[WIDTH-1:0];
                    result_d    = work_d[WIDTH-1:0];
                    zero_d      = (work_d[WIDTH-1:0] == {WIDTH{1'b0}});
                    overflow_d  = 1'b0;
                    out_valid_d = 1'b1;
                end else begin
                    state_d = state_q;
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // State and datapath registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            hi_q        <= {WIDTH{1'b0}};
            lo_q        <= {WIDTH{1'b0}};
            work_q      <= {(2*WIDTH){1'b0}};
            opb_q       <= {WIDTH{1'b0}};
            cnt_q       <= {CNT_W{1'b0}};
            result_q    <= {WIDTH{1'b0}};
            out_valid_q <= 1'b0;
            zero_q      <= 1'b1;
            overflow_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            hi_q        <= hi_d;
            lo_q        <= lo_d;
            work_q      <= work_d;
            opb_q       <= opb_d;
            cnt_q       <= cnt_d;
            result_q    <= result_d;
            out_valid_q <= out_valid_d;
            zero_q      <= zero_d;
            overflow_q  <= overflow_d;
        end
    end

    assign in_ready  = (state_q == S_IDLE);
    assign busy      = (state_q != S_IDLE);
    assign out_valid = out_valid_q;
    assign result    = result_q;
    assign zero      = zero_q;
    assign overflow  = overflow_q;

endmodule

// File: tb/tb_alu_muldiv.sv
// Randomized scoreboard bench for alu_muldiv: a driver pushes expected responses
// from an arithmetic reference model, a negedge monitor pops and compares them.
module tb_alu_muldiv;

    localparam int W = 32;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [3:0]    alu_control = 4'b0000;
    logic [W-1:0]  operand1 = '0, operand2 = '0;
    logic          out_valid, zero, overflow, busy;
    logic [W-1:0]  result;

    logic          in_valid_16 = 1'b0;
    logic          in_ready_16;
    logic [3:0]    alu_control_16 = 4'b0000;
    logic [15:0]   operand1_16 = '0, operand2_16 = '0;
    logic          out_valid_16, zero_16, overflow_16, busy_16;
    logic [15:0]   result_16;

    always #5 clk = ~clk;

    alu_muldiv #(.WIDTH(32), .CNT_W(6)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .alu_control(alu_control), .operand1(operand1), .operand2(operand2),
        .out_valid(out_valid), .result(result), .zero(zero),
        .overflow(overflow), .busy(busy)
    );

    alu_muldiv #(.WIDTH(16), .CNT_W(5)) dut16 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid_16), .in_ready(in_ready_16),
        .alu_control(alu_control_16), .operand1(operand1_16), .operand2(operand2_16),
        .out_valid(out_valid_16), .result(result_16), .zero(zero_16),
        .overflow(overflow_16), .busy(busy_16)
    );

    typedef struct {
        logic [W-1:0] res;
        logic         zero;
        logic         ovf;
        int           when;
    } exp_t;

    exp_t          sb_q[$];
    exp_t          mon_e;
    int            checks = 0;
    int            errors = 0;
    int            cyc = 0;
    logic [W-1:0]  m_hi = '0, m_lo = '0;
    bit            prev_multi = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: every out_valid pulse must match the oldest outstanding expectation.
    always @(negedge clk) begin
        if (rst_n) check("busy_vs_ready", {63'd0, busy}, {63'd0, !in_ready});
        if (out_valid) begin
            if (sb_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_out_valid: got result %0h with nothing expected", result);
            end else begin
                mon_e = sb_q.pop_front();
                check("result",   64'(result),   64'(mon_e.res));
                check("zero",     64'(zero),     64'(mon_e.zero));
                check("overflow", 64'(overflow), 64'(mon_e.ovf));
                check("latency",  64'(cyc),      64'(mon_e.when));
            end
        end
    end

    // Issue one request and push the reference model's expected response.
    task automatic issue(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
        int           waits;
        exp_t         e;
        longint       s;
        logic [63:0]  p;
        bit           multi;
        waits = 0;
        @(negedge clk);
        while (!in_ready && waits < 200) begin
            operand1 = $urandom;
            operand2 = $urandom;
            waits++;
            @(negedge clk);
        end
        check("ready_wait", 64'(waits), prev_multi ? 64'(W + 1) : 64'd0);
        if (!in_ready) begin
            in_valid = 1'b0;
            return;
        end
        alu_control = op;
        operand1    = a;
        operand2    = b;
        in_valid    = 1'b1;
        e.ovf = 1'b0;
        multi = 1'b0;
        case (op)
            4'b0000: e.res = a & b;
            4'b0001: e.res = a | b;
            4'b0010: begin
                s     = longint'($signed(a)) + longint'($signed(b));
                e.res = a + b;
                e.ovf = (s > 64'sd2147483647) || (s < -64'sd2147483648);
            end
            4'b0110: begin
                s     = longint'($signed(a)) - longint'($signed(b));
                e.res = a - b;
                e.ovf = (s > 64'sd2147483647) || (s < -64'sd2147483648);
            end
            4'b0111: e.res = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            4'b1000: e.res = (a < b) ? 32'd1 : 32'd0;
            4'b1100: e.res = ~(a | b);
            4'b1001: begin
                p     = 64'(a) * 64'(b);
                m_hi  = p[63:32];
                m_lo  = p[31:0];
                e.res = m_lo;
                multi = 1'b1;
            end
            4'b1010: begin
                if (b == 32'd0) begin
                    m_hi = a;
                    m_lo = 32'hFFFF_FFFF;
                end else begin
                    m_lo  = a / b;
                    m_hi  = a % b;
                    multi = 1'b1;
                end
                e.res = m_lo;
            end
            4'b1101: e.res = m_hi;
            4'b1110: e.res = m_lo;
            default: e.res = 32'd0;
        endcase
        e.zero = (e.res == 32'd0);
        e.when = cyc + (multi ? W + 1 : 1);
        sb_q.push_back(e);
        prev_multi = multi;
    endtask

    function automatic logic [W-1:0] rnd_operand();
        case ($urandom_range(0, 5))
            0:       return 32'd0;
            1:       return 32'hFFFF_FFFF;
            2:       return 32'h7FFF_FFFF;
            3:       return 32'h8000_0000;
            4:       return 32'($urandom_range(0, 20));
            default: return 32'($urandom);
        endcase
    endfunction

    // Reset in the middle of a multiply: nothing may emerge and HI/LO must clear.
    task automatic abort_mul();
        exp_t dropped;
        issue(4'b1001, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        repeat (9) @(negedge clk);
        in_valid = 1'b0;
        rst_n    = 1'b0;
        #1;
        check("abort_out_valid", 64'(out_valid), 64'd0);
        check("abort_busy",      64'(busy),      64'd0);
        check("abort_result",    64'(result),    64'd0);
        check("abort_zero",      64'(zero),      64'd1);
        dropped    = sb_q.pop_back();
        m_hi       = '0;
        m_lo       = '0;
        prev_multi = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        repeat (W + 5) @(negedge clk);
        issue(4'b1101, '0, '0);
        issue(4'b1110, '0, '0);
    endtask

    logic [3:0] ops [13] = '{4'b0000, 4'b0001, 4'b0010, 4'b0110, 4'b0111, 4'b1000,
                             4'b1100, 4'b1001, 4'b1010, 4'b1101, 4'b1110, 4'b0011, 4'b1111};

    initial begin
        int k;
        int n;
        repeat (3) @(negedge clk);
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_result",    64'(result),    64'd0);
        check("rst_zero",      64'(zero),      64'd1);
        check("rst_overflow",  64'(overflow),  64'd0);
        check("rst_busy",      64'(busy),      64'd0);
        check("rst_in_ready",  64'(in_ready),  64'd1);
        rst_n = 1'b1;

        issue(4'b0010, 32'h7FFF_FFFF, 32'h0000_0001);
        issue(4'b0111, 32'hFFFF_FFFF, 32'h0000_0001);
        issue(4'b1000, 32'hFFFF_FFFF, 32'h0000_0001);
        issue(4'b0110, 32'd5, 32'd5);
        issue(4'b1001, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        issue(4'b1101, '0, '0);
        issue(4'b1010, 32'd100, 32'd7);
        issue(4'b1101, '0, '0);
        issue(4'b1010, 32'd9, 32'd0);
        issue(4'b1101, '0, '0);
        issue(4'b1110, '0, '0);

        for (int i = 0; i < 150; i++) begin
            issue(ops[$urandom_range(0, 12)], rnd_operand(), rnd_operand());
        end

        abort_mul();

        @(negedge clk);
        in_valid = 1'b0;
        n = 0;
        while (sb_q.size() > 0 && n < 100) begin
            @(negedge clk);
            n++;
        end
        check("drain", 64'(sb_q.size()), 64'd0);

        // Narrow instance: full-scale multiply must take WIDTH+1 = 17 cycles.
        @(negedge clk);
        alu_control_16 = 4'b1001;
        operand1_16    = 16'hFFFF;
        operand2_16    = 16'hFFFF;
        in_valid_16    = 1'b1;
        k = cyc;
        @(negedge clk);
        in_valid_16 = 1'b0;
        n = 0;
        while (!out_valid_16 && n < 100) begin
            @(negedge clk);
            n++;
        end
        check("w16_latency", 64'(cyc), 64'(k + 17));
        check("w16_lo",      64'(result_16), 64'h0001);
        n = 0;
        while (!in_ready_16 && n < 100) begin
            @(negedge clk);
            n++;
        end
        alu_control_16 = 4'b1101;
        in_valid_16    = 1'b1;
        @(negedge clk);
        in_valid_16 = 1'b0;
        check("w16_mfhi_valid", 64'(out_valid_16), 64'd1);
        check("w16_mfhi",       64'(result_16),    64'hFFFE);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/alu_muldiv.md
ALU_MULDIV -- requirements
Module: alu_muldiv

Interface
REQ-001 Parameter: WIDTH, default 32, operand/result width in bits (>=8).
REQ-002 Parameter: CNT_W, default 6, iteration counter width; SHALL satisfy 2^CNT_W > WIDTH.
REQ-003 Port: clk  input  1  sole clock; all state updates on rising edge.
REQ-004 Port: rst_n  input  1  asynchronous, active-low reset.
REQ-005 Port: in_valid  input  1  operation request.
REQ-006 Port: in_ready  output  1  block can accept a request this cycle.
REQ-007 Port: alu_control  input  4  operation code, sampled on accept.
REQ-008 Port: operand1, operand2  input  WIDTH each  operands, sampled on accept.
REQ-009 Port: out_valid  output  1  one-cycle pulse, result valid.
REQ-010 Port: result  output  WIDTH  registered result, held until next out_valid.
REQ-011 Port: zero  output  1  registered, high when result == 0, updated with out_valid.
REQ-012 Port: overflow  output  1  registered signed overflow for ADD/SUB, else 0, updated with out_valid.
REQ-013 Port: busy  output  1  high while an iterative op is in progress.

Function
REQ-014 Accept occurs when in_valid && in_ready on a clock edge; in_ready SHALL equal (state == IDLE).
REQ-015 Opcodes: 0000 AND, 0001 OR, 0010 ADD, 0110 SUB, 0111 SLT (signed), 1000 SLTU, 1100 NOR, 1001 MULTU, 1010 DIVU, 1101 MFHI, 1110 MFLO; any other code SHALL yield result 0.
REQ-016 Single-cycle ops (all except MULTU/DIVU): out_valid SHALL pulse on the cycle after accept; state stays IDLE, back-to-back accepts every cycle allowed.
REQ-017 ADD/SUB wrap modulo 2^WIDTH; overflow = sign(op1) and sign(op2 or ~op2) equal and differ from sign(result).
REQ-018 SLT/SLTU result SHALL be zero-extended 1 or 0.
REQ-019 Internal registers HI and LO, WIDTH bits each; MFHI/MFLO return them, unchanged by all other single-cycle ops.
REQ-020 FSM states: IDLE, MUL, DIV, DONE; IDLE->MUL on MULTU accept, IDLE->DIV on DIVU accept with operand2 != 0, MUL/DIV->DONE after exactly WIDTH iterations, DONE->IDLE unconditionally.
REQ-021 MUL: unsigned shift-add, one bit per cycle; on DONE, {HI,LO} SHALL equal full 2*WIDTH-bit product.
REQ-022 DIV: unsigned restoring division, one bit per cycle; on DONE, LO = quotient, HI = remainder.
REQ-023 MULTU/DIVU latency: out_valid pulses exactly WIDTH+1 cycles after accept (in DONE); result = new LO.
REQ-024 DIVU with operand2 == 0: no iteration; out_valid next cycle, HI = operand1, LO = all ones, state stays IDLE.
REQ-025 busy SHALL be high in MUL, DIV and DONE; in_ready low in same states; in_valid then ignored.
REQ-026 HI/LO update only at DONE or divide-by-zero completion; partial values never visible via MFHI/MFLO.

Reset
REQ-027 rst_n low SHALL immediately force state IDLE, HI=LO=0, counter 0, result 0, out_valid 0, zero 1, overflow 0, busy 0.
REQ-028 Reset mid-MUL/DIV SHALL abort the operation with no out_valid and HI/LO cleared; first accept after release behaves as from power-up.

Verification
REQ-029 ADD 0x7FFFFFFF + 0x00000001 -> out_valid cycle+1, result 0x80000000, overflow 1, zero 0.
REQ-030 SLT 0xFFFFFFFF,0x00000001 -> 1; SLTU same operands -> 0; SUB 5,5 -> result 0, zero 1.
REQ-031 MULTU 0xFFFFFFFF x 0xFFFFFFFF -> out_valid exactly 33 cycles after accept, result/LO 0x00000001; MFHI -> 0xFFFFFFFE.
REQ-032 DIVU 100 / 7 -> out_valid at cycle 33, result 14; MFHI -> 2; in_ready low throughout cycles 1-33, in_valid during that time ignored.
REQ-033 DIVU 9 / 0 -> out_valid cycle+1, result 0xFFFFFFFF, MFHI -> 9.
REQ-034 Assert rst_n low at cycle 10 of MULTU -> no out_valid, MFHI/MFLO after release return 0, WIDTH=16 rerun of REQ-031 scaled passes (latency 17).
